// File: rtl/ysyx_22050133_ifid_buf.sv
// ysyx_22050133_ifid_buf: two-entry elastic buffer between fetch (IF) and decode (ID).
// Holds up to two {pc, inst, misalign} entries in FIFO order behind a valid/ready
// handshake. A flush discards all buffered entries and the same-cycle input.
// in_ready depends only on buffer occupancy, so out_ready never reaches fetch
// combinationally.
// Optional: define YSYX_22050133_IFID_PERF_EN to add the perf_stall_cnt and
// perf_flush_cnt counter outputs.
module ysyx_22050133_ifid_buf #(
  parameter int                PC_W     = 64,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
`ifdef YSYX_22050133_IFID_PERF_EN
  output logic [63:0]       perf_stall_cnt,
  output logic [63:0]       perf_flush_cnt,
`endif
  output logic              out_misalign
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              misalign;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, tail_q;
  entry_t in_entry;
  entry_t reset_entry;

  logic enq, deq;
  logic head_load_in, head_load_tail, tail_load;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign enq       = in_valid & in_ready & ~flush;
  assign deq       = out_valid & out_ready;

  // The misalign flag is computed once, at enqueue, and travels with the entry.
  assign in_entry    = '{pc: in_pc, inst: in_inst, misalign: (in_pc[1:0] != 2'b00)};
  assign reset_entry = '{pc: '0, inst: NOP_INST, misalign: 1'b0};

  // Next-state and register-load selection; flush overrides every other transition.
  always_comb begin
    state_d        = state_q;
    head_load_in   = 1'b0;
    head_load_tail = 1'b0;
    tail_load      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (enq) begin
          state_d      = ONE;
          head_load_in = 1'b1;
        end
      end
      ONE: begin
        if (enq && deq) begin
          head_load_in = 1'b1;
        end else if (enq) begin
          state_d   = TWO;
          tail_load = 1'b1;
        end else if (deq) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (deq) begin
          state_d        = ONE;
          head_load_tail = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // enq already excludes flush; also stop the tail shift so out_pc keeps the
    // last head value once the buffer is emptied by the flush.
    if (flush) begin
      state_d        = EMPTY;
      head_load_tail = 1'b0;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Entry storage: written only on a transfer, so outputs stay stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= reset_entry;
      tail_q <= reset_entry;
    end else begin
      if (head_load_in)        head_q <= in_entry;
      else if (head_load_tail) head_q <= tail_q;
      if (tail_load)           tail_q <= in_entry;
    end
  end

  // Decode-facing outputs; the instruction reads as a NOP whenever nothing is valid.
  always_comb begin
    out_pc       = head_q.pc;
    out_inst     = out_valid ? head_q.inst : NOP_INST;
    out_misalign = out_valid & head_q.misalign;
  end

`ifdef YSYX_22050133_IFID_PERF_EN
  // Performance counters: fetch stalls on a full buffer, and flushes that drop live entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 64'd0;
      perf_flush_cnt <= 64'd0;
    end else begin
      if (in_valid && !in_ready)      perf_stall_cnt <= perf_stall_cnt + 64'd1;
      if (flush && (state_q != EMPTY)) perf_flush_cnt <= perf_flush_cnt + 64'd1;
    end
  end
`else
  // This build carries no performance counters.
`endif

endmodule

// File: tb/tb_ysyx_22050133_ifid_buf.sv
// Self-checking bench for ysyx_22050133_ifid_buf: a queue model of the buffer
// predicts handshake outputs and the order/content of every delivered entry.
module tb_ysyx_22050133_ifid_buf;

  localparam int          PC_W   = 64;
  localparam int          INST_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_misalign;
`ifdef YSYX_22050133_IFID_PERF_EN
  logic [63:0]       perf_stall_cnt;
  logic [63:0]       perf_flush_cnt;
`endif

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              mis;
  } ent_t;

  ent_t      sb[$];
  int        total = 0;
  int        bad   = 0;
  longint    stall_exp = 0;
  longint    flush_exp = 0;

  always #5 clk = ~clk;

  ysyx_22050133_ifid_buf #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
`ifdef YSYX_22050133_IFID_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .out_misalign(out_misalign)
  );

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after a posedge, compare at the negedge
  // against the queue model, then advance the model and cross the next posedge.
  task automatic step(input logic v, input logic [63:0] pc, input logic rdy, input logic fl);
    ent_t e;
    int   n;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst_of(pc);
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    n = sb.size();
    check("out_valid", {63'd0, out_valid}, {63'd0, n != 0});
    check("in_ready", {63'd0, in_ready}, {63'd0, n < 2});
    if (n == 0) begin
      check("out_inst_idle", {32'd0, out_inst}, {32'd0, NOP});
      check("out_misalign_idle", {63'd0, out_misalign}, 64'd0);
    end
    if (v && n == 2) stall_exp++;
    if (fl && n != 0) flush_exp++;
    if (n != 0 && rdy) begin
      e = sb.pop_front();
      check("out_pc", out_pc, e.pc);
      check("out_inst", {32'd0, out_inst}, {32'd0, e.inst});
      check("out_misalign", {63'd0, out_misalign}, {63'd0, e.mis});
    end
    if (fl) sb.delete();
    else if (v && n < 2) sb.push_back('{pc: pc, inst: inst_of(pc), mis: (pc[1:0] != 2'b00)});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_inst", {32'd0, out_inst}, {32'd0, NOP});
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_misalign", {63'd0, out_misalign}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 64'h0, 1'b0, 1'b0);

    // Streaming with decode always ready: one entry per cycle, one cycle latency.
    step(1'b1, 64'h8000_0000, 1'b1, 1'b0);
    step(1'b1, 64'h8000_0004, 1'b1, 1'b0);
    step(1'b1, 64'h8000_0008, 1'b1, 1'b0);
    step(1'b0, 64'h0,         1'b1, 1'b0);
    step(1'b0, 64'h0,         1'b1, 1'b0);

    // Backpressure: fill to TWO, fetch holds the third entry until space frees.
    step(1'b1, 64'h8000_0000, 1'b0, 1'b0);
    step(1'b1, 64'h8000_0004, 1'b0, 1'b0);
    step(1'b1, 64'h8000_0008, 1'b0, 1'b0);
    step(1'b1, 64'h8000_0008, 1'b1, 1'b0);
    step(1'b1, 64'h8000_0008, 1'b1, 1'b0);
    step(1'b0, 64'h0,         1'b1, 1'b0);
    step(1'b0, 64'h0,         1'b1, 1'b0);

    // Flush while TWO with a fetch pending: all entries and the input vanish.
    step(1'b1, 64'h8000_0020, 1'b0, 1'b0);
    step(1'b1, 64'h8000_0024, 1'b0, 1'b0);
    step(1'b1, 64'h8000_0010, 1'b0, 1'b1);
    step(1'b0, 64'h0,         1'b1, 1'b0);
    check("flush_two_inst", {32'd0, out_inst}, {32'd0, NOP});

    // Flush in ONE with a same-cycle dequeue: the dequeue completes, input dropped.
    step(1'b1, 64'h8000_0030, 1'b0, 1'b0);
    step(1'b1, 64'h8000_0034, 1'b1, 1'b1);
    step(1'b0, 64'h0,         1'b1, 1'b0);

    // Simultaneous enqueue and dequeue in ONE keeps a single entry.
    step(1'b1, 64'h8000_0000, 1'b0, 1'b0);
    step(1'b1, 64'h8000_0004, 1'b1, 1'b0);
    check("enq_deq_pc", out_pc, 64'h8000_0004);
    check("enq_deq_in_ready", {63'd0, in_ready}, 64'd1);
    step(1'b0, 64'h0,         1'b1, 1'b0);

    // Misaligned pc carries the flag with its entry.
    step(1'b1, 64'h8000_0002, 1'b0, 1'b0);
    check("misalign_head", {63'd0, out_misalign}, 64'd1);
    step(1'b1, 64'h8000_0006, 1'b0, 1'b0);
    step(1'b1, 64'h8000_0008, 1'b0, 1'b0);

`ifdef YSYX_22050133_IFID_PERF_EN
    check("perf_stall_cnt", perf_stall_cnt, stall_exp);
    check("perf_flush_cnt", perf_flush_cnt, flush_exp);
`endif

    // Asynchronous reset mid-stream empties the buffer before the next edge.
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_inst", {32'd0, out_inst}, {32'd0, NOP});
    check("midrst_out_pc", out_pc, 64'd0);
    check("midrst_misalign", {63'd0, out_misalign}, 64'd0);
`ifdef YSYX_22050133_IFID_PERF_EN
    check("midrst_perf_stall", perf_stall_cnt, 64'd0);
    check("midrst_perf_flush", perf_flush_cnt, 64'd0);
`endif
    sb.delete();
    stall_exp = 0;
    flush_exp = 0;
    in_valid  = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    step(1'b1, 64'h8000_0040, 1'b1, 1'b0);
    step(1'b0, 64'h0,         1'b1, 1'b0);
    check("queue_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
